// File: rtl/snitch_icache_pkg.sv
// Shared instruction-cache types: per-port L0 event vector and performance-counter helpers.
package snitch_icache_pkg;

    // Bit position in the packed struct is the event index (l0_stall is bit 0).
    typedef struct packed {
        logic l0_miss;
        logic l0_hit;
        logic l0_prefetch;
        logic l0_double_hit;
        logic l0_stall;
    } icache_events_t;

    localparam int unsigned NR_ICACHE_EVENTS = $bits(icache_events_t);

    typedef enum logic [2:0] {
        STALL      = 3'd0,
        DOUBLE_HIT = 3'd1,
        PREFETCH   = 3'd2,
        HIT        = 3'd3,
        MISS       = 3'd4
    } icache_event_idx_e;

    typedef struct packed {
        logic [6:0] cnt_width;
        logic       saturate;
        logic       shadow;
    } perf_cnt_cfg_t;

    // Flat position of a (port, event) pair in the overflow vector.
    function automatic int unsigned ovf_idx(input int unsigned port, input int unsigned ev);
        return port * NR_ICACHE_EVENTS + ev;
    endfunction

endpackage

// File: rtl/snitch_icache_perf_cnt_cell.sv
// One event counter with clear, wrap/saturate overflow handling and a sticky overflow flag.
module snitch_icache_perf_cnt_cell #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter bit          SATURATE  = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inc_i,
    input  logic                 clear_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 ovf_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 ovf_q;
    logic [CNT_WIDTH:0]   sum;

    // The extra top bit is the carry-out, which is exactly the overflow condition.
    assign sum = {1'b0, cnt_q} + {{CNT_WIDTH{1'b0}}, 1'b1};

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (inc_i) begin
            if (sum[CNT_WIDTH]) begin
                ovf_q <= 1'b1;
            end
            if (!(SATURATE && sum[CNT_WIDTH])) begin
                cnt_q <= sum[CNT_WIDTH-1:0];
            end
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/snitch_icache_perf_cnt.sv
// Per-port instruction-cache event counter bank with snapshot shadow, overflow irq and
// a registered single-cycle read port.
module snitch_icache_perf_cnt
    import snitch_icache_pkg::*;
#(
    parameter int unsigned NR_FETCH_PORTS = 2,
    parameter int unsigned CNT_WIDTH      = 32,
    parameter bit          SATURATE       = 1'b0,
    parameter bit          SHADOW         = 1'b1,
    localparam int unsigned PortIdxW      = (NR_FETCH_PORTS > 1) ? $clog2(NR_FETCH_PORTS) : 1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  icache_events_t [NR_FETCH_PORTS-1:0]      events_i,
    input  logic                                     enable_i,
    input  logic                                     clear_i,
    input  logic                                     snapshot_i,
    input  logic                                     rd_req_i,
    input  logic [PortIdxW-1:0]                      rd_port_i,
    input  logic [2:0]                               rd_event_i,
    output logic                                     rd_valid_o,
    output logic [CNT_WIDTH-1:0]                     rd_data_o,
    output logic                                     rd_err_o,
    output logic [NR_FETCH_PORTS*NR_ICACHE_EVENTS-1:0] ovf_o,
    output logic                                     irq_o
);

    logic [CNT_WIDTH-1:0] live   [NR_FETCH_PORTS][NR_ICACHE_EVENTS];
    logic [CNT_WIDTH-1:0] shadow_q [NR_FETCH_PORTS][NR_ICACHE_EVENTS];
    logic [NR_FETCH_PORTS*NR_ICACHE_EVENTS-1:0] ovf;

    for (genvar p = 0; p < NR_FETCH_PORTS; p++) begin : gen_port
        for (genvar e = 0; e < NR_ICACHE_EVENTS; e++) begin : gen_event
            snitch_icache_perf_cnt_cell #(
                .CNT_WIDTH (CNT_WIDTH),
                .SATURATE  (SATURATE)
            ) i_cell (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .inc_i   (enable_i & events_i[p][e]),
                .clear_i (clear_i),
                .cnt_o   (live[p][e]),
                .ovf_o   (ovf[ovf_idx(p, e)])
            );
        end
    end

    // Snapshot takes the pre-edge live values, so same-cycle increments and clears are excluded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q <= '{default: '0};
        end else if (snapshot_i) begin
            shadow_q <= live;
        end
    end

    logic                 rd_hit;
    logic [CNT_WIDTH-1:0] rd_sel;

    // A matching (port, event) pair exists only for in-range indices; no match means error.
    always_comb begin
        rd_hit = 1'b0;
        rd_sel = '0;
        for (int p = 0; p < NR_FETCH_PORTS; p++) begin
            for (int e = 0; e < NR_ICACHE_EVENTS; e++) begin
                if (rd_port_i == PortIdxW'(p) && rd_event_i == 3'(e)) begin
                    rd_hit = 1'b1;
                    rd_sel = SHADOW ? shadow_q[p][e] : live[p][e];
                end
            end
        end
    end

    logic                 rd_valid_q;
    logic [CNT_WIDTH-1:0] rd_data_q;
    logic                 rd_err_q;
    logic                 irq_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            rd_valid_q <= rd_req_i;
            irq_q      <= |ovf;
            if (rd_req_i) begin
                rd_data_q <= rd_hit ? rd_sel : '0;
                rd_err_q  <= ~rd_hit;
            end
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign rd_err_o   = rd_err_q;
    assign ovf_o      = ovf;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_snitch_icache_perf_cnt.sv
// Bench: a wrapping/shadow bank and a saturating/live bank share stimulus, checked against a model.
module tb_snitch_icache_perf_cnt;
    import snitch_icache_pkg::*;

    localparam int NP  = 3;
    localparam int W   = 4;
    localparam int PW  = 2;
    localparam int MAX = (1 << W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [NP-1:0][4:0]   events;
    logic                 enable, clear, snapshot, rd_req;
    logic [PW-1:0]        rd_port;
    logic [2:0]           rd_event;

    logic                 a_valid, a_err, a_irq, b_valid, b_err, b_irq;
    logic [W-1:0]         a_data, b_data;
    logic [NP*5-1:0]      a_ovf, b_ovf;

    snitch_icache_perf_cnt #(.NR_FETCH_PORTS(NP), .CNT_WIDTH(W), .SATURATE(1'b0), .SHADOW(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst), .events_i(events), .enable_i(enable), .clear_i(clear),
        .snapshot_i(snapshot), .rd_req_i(rd_req), .rd_port_i(rd_port), .rd_event_i(rd_event),
        .rd_valid_o(a_valid), .rd_data_o(a_data), .rd_err_o(a_err), .ovf_o(a_ovf), .irq_o(a_irq));

    snitch_icache_perf_cnt #(.NR_FETCH_PORTS(NP), .CNT_WIDTH(W), .SATURATE(1'b1), .SHADOW(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .events_i(events), .enable_i(enable), .clear_i(clear),
        .snapshot_i(snapshot), .rd_req_i(rd_req), .rd_port_i(rd_port), .rd_event_i(rd_event),
        .rd_valid_o(b_valid), .rd_data_o(b_data), .rd_err_o(b_err), .ovf_o(b_ovf), .irq_o(b_irq));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Model state, index 0 = wrap/shadow bank, 1 = saturate/live bank.
    int live_m [2][NP][5];
    int sh_m   [2][NP][5];
    bit ovf_m  [2][NP*5];
    bit exp_valid [2];
    int exp_data  [2];
    bit exp_err   [2];
    bit exp_irq   [2];

    task automatic idle();
        rst = 1'b0; events = '0; enable = 1'b0; clear = 1'b0; snapshot = 1'b0;
        rd_req = 1'b0; rd_port = '0; rd_event = '0;
    endtask

    task automatic step();
        logic [NP*5-1:0] ov [2];
        for (int d = 0; d < 2; d++) begin
            bit any;
            if (rst) begin
                for (int p = 0; p < NP; p++)
                    for (int e = 0; e < 5; e++) begin
                        live_m[d][p][e] = 0; sh_m[d][p][e] = 0; ovf_m[d][p*5+e] = 0;
                    end
                exp_valid[d] = 0; exp_data[d] = 0; exp_err[d] = 0; exp_irq[d] = 0;
                continue;
            end
            exp_valid[d] = rd_req;
            if (rd_req) begin
                if (int'(rd_port) >= NP || int'(rd_event) > 4) begin
                    exp_err[d] = 1; exp_data[d] = 0;
                end else begin
                    exp_err[d]  = 0;
                    exp_data[d] = (d == 0) ? sh_m[d][rd_port][rd_event] : live_m[d][rd_port][rd_event];
                end
            end
            any = 0;
            for (int i = 0; i < NP*5; i++) any |= ovf_m[d][i];
            exp_irq[d] = any;
            if (snapshot) sh_m[d] = live_m[d];
            for (int p = 0; p < NP; p++)
                for (int e = 0; e < 5; e++) begin
                    if (clear) begin
                        live_m[d][p][e] = 0; ovf_m[d][p*5+e] = 0;
                    end else if (enable && events[p][e]) begin
                        if (live_m[d][p][e] == MAX) begin
                            ovf_m[d][p*5+e] = 1;
                            live_m[d][p][e] = (d == 1) ? MAX : 0;
                        end else begin
                            live_m[d][p][e] += 1;
                        end
                    end
                end
        end
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NP*5; i++) ov[d][i] = ovf_m[d][i];
        chk("a_valid", 32'(a_valid), 32'(exp_valid[0]));
        chk("a_data",  32'(a_data),  32'(exp_data[0]));
        chk("a_err",   32'(a_err),   32'(exp_err[0]));
        chk("a_irq",   32'(a_irq),   32'(exp_irq[0]));
        chk("a_ovf",   32'(a_ovf),   32'(ov[0]));
        chk("b_valid", 32'(b_valid), 32'(exp_valid[1]));
        chk("b_data",  32'(b_data),  32'(exp_data[1]));
        chk("b_err",   32'(b_err),   32'(exp_err[1]));
        chk("b_irq",   32'(b_irq),   32'(exp_irq[1]));
        chk("b_ovf",   32'(b_ovf),   32'(ov[1]));
    endtask

    task automatic read(input int p, input int e);
        idle(); rd_req = 1'b1; rd_port = PW'(p); rd_event = 3'(e); step();
    endtask

    int resp_cnt;

    initial begin
        for (int d = 0; d < 2; d++) begin
            exp_valid[d] = 0; exp_data[d] = 0; exp_err[d] = 0; exp_irq[d] = 0;
        end
        idle(); rst = 1'b1; step(); step();

        // Reset read of p0/e3.
        read(0, HIT);
        chk("t1_valid", 32'(a_valid), 32'd1);
        chk("t1_data",  32'(a_data),  32'd0);
        chk("t1_err",   32'(a_err),   32'd0);
        chk("t1_irq",   32'(a_irq),   32'd0);

        // Seven hits on port 1, snapshot, read back.
        for (int i = 0; i < 7; i++) begin
            idle(); enable = 1'b1; events[1][HIT] = 1'b1; step();
        end
        idle(); snapshot = 1'b1; step();
        read(1, HIT);
        chk("t2_p1_hit_a", 32'(a_data), 32'd7);
        chk("t2_p1_hit_b", 32'(b_data), 32'd7);
        read(0, HIT);
        chk("t2_p0_hit", 32'(a_data), 32'd0);

        // Sixteen misses on port 0 overflow a 4-bit counter.
        for (int i = 0; i < 16; i++) begin
            idle(); enable = 1'b1; events[0][MISS] = 1'b1; step();
        end
        chk("t3_ovf_a", 32'(a_ovf[4]), 32'd1);
        chk("t3_ovf_b", 32'(b_ovf[4]), 32'd1);
        chk("t3_irq_lag", 32'(a_irq), 32'd0);
        idle(); snapshot = 1'b1; step();
        chk("t3_irq_a", 32'(a_irq), 32'd1);
        chk("t3_irq_b", 32'(b_irq), 32'd1);
        read(0, MISS);
        chk("t3_wrap", 32'(a_data), 32'd0);
        chk("t3_sat",  32'(b_data), 32'd15);

        // clear + snapshot + event together with live = 5.
        idle(); clear = 1'b1; step();
        for (int i = 0; i < 5; i++) begin
            idle(); enable = 1'b1; events[0][STALL] = 1'b1; step();
        end
        idle(); enable = 1'b1; events[0][STALL] = 1'b1; clear = 1'b1; snapshot = 1'b1; step();
        chk("t4_ovf", 32'(a_ovf), 32'd0);
        read(0, STALL);
        chk("t4_shadow", 32'(a_data), 32'd5);
        chk("t4_live",   32'(b_data), 32'd0);
        idle(); snapshot = 1'b1; step();
        read(0, STALL);
        chk("t4_live_a", 32'(a_data), 32'd0);

        // Out-of-range index, then back-to-back reads.
        read(NP, 5);
        chk("t5_err",  32'(a_err),  32'd1);
        chk("t5_data", 32'(a_data), 32'd0);
        read(NP - 1, 7);
        chk("t5_err_ev", 32'(b_err), 32'd1);
        resp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            read(i, i);
            if (a_valid) resp_cnt++;
        end
        chk("t5_b2b", 32'(resp_cnt), 32'd3);

        // Reset while counting with a read in flight.
        for (int i = 0; i < 20; i++) begin
            idle(); enable = 1'b1; events = '1; step();
        end
        idle(); enable = 1'b1; events = '1; rd_req = 1'b1; rd_port = 2'd1; rd_event = 3'd3; step();
        idle(); rst = 1'b1; enable = 1'b1; events = '1; step();
        chk("t6_valid", 32'(a_valid), 32'd0);
        chk("t6_irq",   32'(a_irq),   32'd0);
        chk("t6_ovf",   32'(b_ovf),   32'd0);
        read(2, MISS);
        chk("t6_live", 32'(b_data), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            enable   = ($urandom_range(0, 9) != 0);
            clear    = ($urandom_range(0, 59) == 0);
            snapshot = ($urandom_range(0, 5) == 0);
            rd_req   = ($urandom_range(0, 2) != 0);
            rd_port  = PW'($urandom_range(0, 3));
            rd_event = 3'($urandom_range(0, 7));
            events   = (NP*5)'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
